// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes one instruction, drives registered operands
// and control code to an external combinational ALU, captures the result and
// presents it on a valid/ready response port. One request in flight at a time.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [15:0] imm,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [2:0]  alu_cont,
    input  logic [31:0] alu_result,
    input  logic        alu_z,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_branch_taken,
    output logic        rsp_illegal
);

    // state   | meaning
    // IDLE    | waiting for a request, req_ready high
    // ISSUE   | operands driven to ALU, one settling cycle
    // CAPTURE | ALU output sampled on the edge leaving this state
    // RESP    | response held until rsp_ready
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t      state;
    logic        beq_q;

    logic        dec_legal;
    logic        dec_beq;
    logic [2:0]  dec_cont;
    logic [31:0] dec_op2;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;

    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0000, imm};

    // Instruction decode into ALU control code and second operand
    always_comb begin
        dec_legal = 1'b1;
        dec_beq   = 1'b0;
        dec_cont  = 3'b010;
        dec_op2   = rt_val;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100000: dec_cont = 3'b010;
                    6'b100010: dec_cont = 3'b110;
                    6'b100100: dec_cont = 3'b000;
                    6'b100101: dec_cont = 3'b001;
                    6'b101010: dec_cont = 3'b111;
                    default:   dec_legal = 1'b0;
                endcase
            end
            6'b100011, 6'b101011, 6'b001000: begin
                dec_cont = 3'b010;
                dec_op2  = imm_sext;
            end
            6'b000100: begin
                dec_cont = 3'b110;
                dec_beq  = 1'b1;
            end
            6'b001100: begin
                dec_cont = 3'b000;
                dec_op2  = imm_zext;
            end
            6'b001101: begin
                dec_cont = 3'b001;
                dec_op2  = imm_zext;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Handshake flags decode directly from the state register
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // Sequencing FSM with registered ALU drive and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            beq_q            <= 1'b0;
            alu_op1          <= '0;
            alu_op2          <= '0;
            alu_cont         <= 3'b000;
            rsp_result       <= '0;
            rsp_zero         <= 1'b0;
            rsp_branch_taken <= 1'b0;
            rsp_illegal      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (dec_legal) begin
                            alu_op1  <= rs_val;
                            alu_op2  <= dec_op2;
                            alu_cont <= dec_cont;
                            beq_q    <= dec_beq;
                            state    <= ISSUE;
                        end else begin
                            // Illegal requests bypass the ALU and leave its inputs untouched
                            rsp_result       <= '0;
                            rsp_zero         <= 1'b0;
                            rsp_branch_taken <= 1'b0;
                            rsp_illegal      <= 1'b1;
                            state            <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_result       <= alu_result;
                    rsp_zero         <= alu_z;
                    rsp_branch_taken <= alu_z && beq_q;
                    rsp_illegal      <= 1'b0;
                    state            <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 req_valid  input  1  instruction request valid.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 opcode  input  6  instruction bits [31:26].
REQ-007 funct  input  6  instruction bits [5:0].
REQ-008 rs_val  input  32  first source register value.
REQ-009 rt_val  input  32  second source register value.
REQ-010 imm  input  16  instruction bits [15:0].
REQ-011 alu_op1  output  32  registered operand 1 to ALU.
REQ-012 alu_op2  output  32  registered operand 2 to ALU.
REQ-013 alu_cont  output  3  registered ALU control code to ALU.
REQ-014 alu_result  input  32  combinational ALU result.
REQ-015 alu_z  input  1  ALU zero flag.
REQ-016 rsp_valid  output  1  response valid.
REQ-017 rsp_ready  input  1  consumer accepts response.
REQ-018 rsp_result  output  32  captured ALU result.
REQ-019 rsp_zero  output  1  captured ALU zero flag.
REQ-020 rsp_branch_taken  output  1  beq condition met.
REQ-021 rsp_illegal  output  1  request was not a supported instruction.

Function
REQ-022 FSM states SHALL be IDLE, ISSUE, CAPTURE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-023 Request accepted on the edge where req_valid && req_ready; inputs SHALL be sampled on that edge only and ignored otherwise.
REQ-024 Decode (opcode/funct -> alu_cont, op2): R-type 000000 with funct 100000 add->010, 100010 sub->110, 100100 and->000, 100101 or->001, 101010 slt->111, op2=rt_val.
REQ-025 Decode: lw 100011 and sw 101011 ->010, addi 001000 ->010, op2=sign-extended imm; beq 000100 ->110, op2=rt_val; andi 001100 ->000, ori 001101 ->001, op2=zero-extended imm.
REQ-026 alu_op1 SHALL be rs_val for every legal instruction.
REQ-027 Legal accept: IDLE->ISSUE; alu_op1/op2/cont loaded on accept edge and held stable through ISSUE and CAPTURE.
REQ-028 ISSUE->CAPTURE unconditionally (one settling cycle); on the CAPTURE->RESP edge rsp_result<=alu_result, rsp_zero<=alu_z, rsp_branch_taken<=alu_z && instruction was beq, rsp_illegal<=0.
REQ-029 Legal latency: accept at edge T -> rsp_valid high from edge T+3.
REQ-030 Any other opcode, or R-type with other funct, SHALL be illegal: IDLE->RESP directly, rsp_valid from edge T+1, rsp_result=0, rsp_zero=0, rsp_branch_taken=0, rsp_illegal=1; alu_op1/op2/cont SHALL NOT change.
REQ-031 rsp_valid=1 exactly in RESP; rsp_* SHALL hold stable while rsp_valid && !rsp_ready.
REQ-032 RESP->IDLE on edge with rsp_ready=1; no new request accepted on that same edge (req_ready=0 in RESP).
REQ-033 alu_op1/op2/cont SHALL retain last issued values in IDLE and RESP.
REQ-034 Single outstanding request; no queuing.

Reset
REQ-035 On rst_n low, SHALL immediately enter IDLE regardless of state, abandoning any in-flight request without producing a response.
REQ-036 Reset values: req_ready=1 (IDLE), rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_branch_taken=0, rsp_illegal=0, alu_op1=0, alu_op2=0, alu_cont=000.
REQ-037 First accept possible on first rising edge after rst_n deasserts.

Verification
REQ-038 add: funct 100000, rs=5, rt=3, ALU model returns 8 -> alu_cont=010, op1=5, op2=3; rsp_valid at T+3, rsp_result=8, rsp_zero=0, illegal=0.
REQ-039 beq: rs=rt=0x00001234, ALU model returns 0, z=1 -> alu_cont=110, rsp_zero=1, rsp_branch_taken=1; rs=1, rt=2 -> branch_taken=0.
REQ-040 lw imm 0xFFFC -> alu_op2=0xFFFFFFFC, alu_cont=010; ori imm 0x8000 -> alu_op2=0x00008000, alu_cont=001; slt -> alu_cont=111.
REQ-041 opcode 111111 -> rsp_valid at T+1, rsp_illegal=1, rsp_result=0, alu_* unchanged from previous issue.
REQ-042 rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_* stable, req_ready=0, req_valid ignored; rsp_ready=1 -> IDLE next edge, req_ready=1.
REQ-043 rst_n asserted during CAPTURE -> IDLE immediately, rsp_valid stays 0, all outputs at reset values; next request completes normally.
